// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA decrypt engine: keystream from the shared S memory, XOR with the encrypted ROM, plaintext to the RAM.
// Build option PLAINTEXT_CHECK_EN aborts the run (key_fail) on the first byte outside 'a'..'z' / space.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int K_W     = $clog2(MSG_LEN)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           key_fail,
    output logic [7:0]     s_addr,
    output logic [7:0]     s_wdata,
    output logic           s_wren,
    input  logic [7:0]     s_rdata,
    output logic [K_W-1:0] e_addr,
    input  logic [7:0]     e_rdata,
    output logic [K_W-1:0] d_addr,
    output logic [7:0]     d_wdata,
    output logic           d_wren
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] INC_I  = 4'd1;
    localparam logic [3:0] RD_SI  = 4'd2;
    localparam logic [3:0] CALC_J = 4'd3;
    localparam logic [3:0] RD_SJ  = 4'd4;
    localparam logic [3:0] LD_SJ  = 4'd5;
    localparam logic [3:0] WR_I   = 4'd6;
    localparam logic [3:0] WR_J   = 4'd7;
    localparam logic [3:0] RD_F   = 4'd8;
    localparam logic [3:0] LD_F   = 4'd9;
    localparam logic [3:0] WR_D   = 4'd10;
    localparam logic [3:0] DONE   = 4'd11;

    logic [3:0]     state;
    logic [7:0]     i, j, si, sj, f, e;
    logic [K_W-1:0] k;
    logic [7:0]     plain;
    logic           last_byte;
    logic           plain_bad;

    assign plain     = f ^ e;
    assign last_byte = (k == K_W'(MSG_LEN - 1));

`ifdef PLAINTEXT_CHECK_EN
    assign plain_bad = !(((plain >= 8'h61) && (plain <= 8'h7a)) || (plain == 8'h20));
`else
    assign plain_bad = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            si       <= '0;
            sj       <= '0;
            f        <= '0;
            e        <= '0;
            k        <= '0;
            key_fail <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        key_fail <= 1'b0;
                        state    <= INC_I;
                    end
                end
                INC_I: begin
                    i     <= i + 8'd1;
                    state <= RD_SI;
                end
                RD_SI:  state <= CALC_J;
                CALC_J: begin
                    si    <= s_rdata;
                    j     <= j + s_rdata;
                    state <= RD_SJ;
                end
                RD_SJ:  state <= LD_SJ;
                LD_SJ: begin
                    sj    <= s_rdata;
                    state <= WR_I;
                end
                // i == j needs no special case: both writes land on one cell with its own value
                WR_I:   state <= WR_J;
                WR_J:   state <= RD_F;
                RD_F:   state <= LD_F;
                LD_F: begin
                    f     <= s_rdata;
                    e     <= e_rdata;
                    state <= WR_D;
                end
                WR_D: begin
                    if (plain_bad) begin
                        key_fail <= 1'b1;
                        state    <= DONE;
                    end else if (last_byte) begin
                        state <= DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= INC_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no latch can be inferred.
    always_comb begin
        s_addr  = 8'd0;
        s_wdata = 8'd0;
        s_wren  = 1'b0;
        d_wren  = 1'b0;
        case (state)
            RD_SI: s_addr = i;
            RD_SJ: s_addr = j;
            WR_I: begin
                s_addr  = i;
                s_wdata = sj;
                s_wren  = 1'b1;
            end
            WR_J: begin
                s_addr  = j;
                s_wdata = si;
                s_wren  = 1'b1;
            end
            RD_F:  s_addr = si + sj;
            WR_D:  d_wren = 1'b1;
            default: ;
        endcase
    end

    assign e_addr  = k;
    assign d_addr  = k;
    assign d_wdata = plain;
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: default 32-byte instance plus a 256-byte instance.
// Define PLAINTEXT_CHECK_EN to exercise the early-abort build instead of the full-length runs.
module tb_rc4_prga_decrypt;

    typedef struct {
        int         k;
        logic [7:0] e;
        logic [7:0] d;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n, start, start2, load_req;

    logic       busy, done, key_fail, s_wren, d_wren;
    logic [7:0] s_addr, s_wdata, s_rdata, e_rdata, d_wdata;
    logic [4:0] e_addr, d_addr;

    logic       busy2, done2, key_fail2, s_wren2, d_wren2;
    logic [7:0] s_addr2, s_wdata2, s_rdata2, e_rdata2, d_wdata2;
    logic [7:0] e_addr2, d_addr2;

    logic [7:0] s_mem[256], s_init[256], e_mem[32], d_mem[32];
    logic [7:0] s_mem2[256], s_init2[256], e_mem2[256], d_mem2[256];
    logic [7:0] ms[256], me[256], md[256];

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0, order_err = 0, wr_cnt2 = 0, order_err2 = 0;
    logic [4:0] exp_next = '0;
    logic [7:0] exp_next2 = '0, last_addr2 = '0;
    logic [7:0] snap2 = '0, snap3 = '0;
    logic       snap_valid = 1'b0;

    always #5 clk = ~clk;

    rc4_prga_decrypt dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .key_fail(key_fail), .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren),
        .s_rdata(s_rdata), .e_addr(e_addr), .e_rdata(e_rdata), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wren(d_wren)
    );

    rc4_prga_decrypt #(.MSG_LEN(256)) dut256 (
        .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
        .key_fail(key_fail2), .s_addr(s_addr2), .s_wdata(s_wdata2), .s_wren(s_wren2),
        .s_rdata(s_rdata2), .e_addr(e_addr2), .e_rdata(e_rdata2), .d_addr(d_addr2),
        .d_wdata(d_wdata2), .d_wren(d_wren2)
    );

    // Memory models: synchronous read, 1-cycle latency; load_req preloads S and fills D with 0xAA.
    always @(posedge clk) begin
        s_rdata  <= s_mem[s_addr];
        e_rdata  <= e_mem[e_addr];
        s_rdata2 <= s_mem2[s_addr2];
        e_rdata2 <= e_mem2[e_addr2];
        if (load_req) begin
            s_mem  <= s_init;
            s_mem2 <= s_init2;
            d_mem  <= '{default: 8'haa};
            d_mem2 <= '{default: 8'haa};
        end else begin
            if (s_wren)  s_mem[s_addr]   <= s_wdata;
            if (d_wren)  d_mem[d_addr]   <= d_wdata;
            if (s_wren2) s_mem2[s_addr2] <= s_wdata2;
            if (d_wren2) d_mem2[d_addr2] <= d_wdata2;
        end
    end

    // Write monitors: count d writes and flag any address out of ascending order within a run.
    always @(posedge clk) begin
        if (d_wren) begin
            if (d_addr != exp_next) order_err <= order_err + 1;
            exp_next <= d_addr + 5'd1;
            wr_cnt   <= wr_cnt + 1;
            if (d_addr == 5'd1 && !snap_valid) begin
                snap2      <= s_mem[2];
                snap3      <= s_mem[3];
                snap_valid <= 1'b1;
            end
        end else if (!busy) begin
            exp_next <= '0;
        end
        if (d_wren2) begin
            if (d_addr2 != exp_next2) order_err2 <= order_err2 + 1;
            exp_next2  <= d_addr2 + 8'd1;
            last_addr2 <= d_addr2;
            wr_cnt2    <= wr_cnt2 + 1;
        end else if (!busy2) begin
            exp_next2 <= '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_load();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic wait_done(input bit big, output int edges);
        edges = 0;
        while (edges < 3000) begin
            @(posedge clk);
            edges++;
            #1;
            if (big ? done2 : done) break;
        end
        check("done_reached", big ? done2 : done, 1);
    endtask

    task automatic run(input bit big, input bit hold, output int edges);
        @(negedge clk);
        if (big) start2 = 1'b1;
        else     start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start  = 1'b0;
            start2 = 1'b0;
        end
        check("busy_after_start", big ? busy2 : busy, 1);
        check("done_cleared", big ? done2 : done, 0);
        wait_done(big, edges);
    endtask

    // Textbook RC4 PRGA over ms[], XORing with me[] into md[].
    task automatic model_prga(input int n);
        int         ii, jj;
        logic [7:0] t;
        ii = 0;
        jj = 0;
        for (int k = 0; k < n; k++) begin
            ii     = (ii + 1) % 256;
            jj     = (jj + int'(ms[ii])) % 256;
            t      = ms[ii];
            ms[ii] = ms[jj];
            ms[jj] = t;
            md[k]  = ms[(int'(ms[ii]) + int'(ms[jj])) % 256] ^ me[k];
        end
    endtask

    initial begin
        vec_t       id_vecs[6];
        logic [7:0] key[3];
        int         edges, base, oe, jj;
        logic [7:0] t;

        reset_n  = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        load_req = 1'b0;
        for (int x = 0; x < 256; x++) begin
            s_init[x]  = 8'(x);
            s_init2[x] = 8'(x);
            e_mem2[x]  = 8'h00;
        end
        for (int x = 0; x < 32; x++) e_mem[x] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_key_fail", key_fail, 0);
        check("rst_wren", {s_wren, d_wren, s_wren2, d_wren2}, 0);
        check("rst_addr", {s_addr, 3'b0, e_addr, 3'b0, d_addr}, 0);
        check("rst_busy_done_256", {busy2, done2}, 0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef PLAINTEXT_CHECK_EN
        // 0x02^0x63 = 'a' passes; byte 1 = 0x05 fails and ends the run after its write.
        e_mem[0] = 8'h63;
        do_load();
        base = wr_cnt;
        run(0, 0, edges);
        check("abort_done_edge", edges, 20);
        check("abort_key_fail", key_fail, 1);
        check("abort_writes", wr_cnt - base, 2);
        check("abort_d0", d_mem[0], 8'h61);
        check("abort_d1", d_mem[1], 8'h05);
        check("abort_no_d2", d_mem[2], 8'haa);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("key_fail_cleared", key_fail, 0);
        wait_done(0, edges);
`else
        // Identity S: keystream 02 05 07 0d 0d 17 for the first six bytes.
        id_vecs[0] = '{0, 8'h00, 8'h02};
        id_vecs[1] = '{1, 8'h00, 8'h05};
        id_vecs[2] = '{2, 8'h60, 8'h67};
        id_vecs[3] = '{3, 8'hff, 8'hf2};
        id_vecs[4] = '{4, 8'h0d, 8'h00};
        id_vecs[5] = '{5, 8'h80, 8'h97};
        foreach (id_vecs[v]) e_mem[id_vecs[v].k] = id_vecs[v].e;
        do_load();
        base = wr_cnt;
        run(0, 0, edges);
        check("id_done_edge", edges, 320);
        foreach (id_vecs[v]) check($sformatf("id_d%0d", id_vecs[v].k), d_mem[id_vecs[v].k], id_vecs[v].d);
        check("id_s2_after_byte1", snap2, 8'h03);
        check("id_s3_after_byte1", snap3, 8'h02);
        check("id_writes", wr_cnt - base, 32);
        check("id_order", order_err, 0);
        check("id_key_fail", key_fail, 0);

        // Key 0x000249 through KSA, then full PRGA scoreboard.
        key[0] = 8'h00;
        key[1] = 8'h02;
        key[2] = 8'h49;
        for (int x = 0; x < 256; x++) ms[x] = 8'(x);
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj     = (jj + int'(ms[x]) + int'(key[x % 3])) % 256;
            t      = ms[x];
            ms[x]  = ms[jj];
            ms[jj] = t;
        end
        for (int x = 0; x < 256; x++) s_init[x] = ms[x];
        for (int x = 0; x < 32; x++) begin
            me[x]    = 8'((x * 37 + 11) % 256);
            e_mem[x] = me[x];
        end
        model_prga(32);
        do_load();
        run(0, 0, edges);
        check("ksa_done_edge", edges, 320);
        for (int x = 0; x < 32; x++) check($sformatf("ksa_d%0d", x), d_mem[x], md[x]);
        for (int x = 0; x < 256; x++) check($sformatf("ksa_s%0d", x), s_mem[x], ms[x]);

        // Reset asserted while byte 5 sits in WR_D.
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        do_load();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        while (edges < 200 && !(d_wren && d_addr == 5'd5)) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check("reached_byte5", {d_wren, 3'b0, d_addr}, {1'b1, 3'b0, 5'd5});
        reset_n = 1'b0;
        #1;
        check("mid_rst_wren", {s_wren, d_wren}, 0);
        check("mid_rst_busy_done", {busy, done}, 0);
        @(posedge clk);
        #1;
        check("mid_rst_no_d5", d_mem[5], 8'haa);
        @(negedge clk);
        reset_n = 1'b1;
        base = wr_cnt;
        oe   = order_err;
        run(0, 0, edges);
        check("rerun_done_edge", edges, 320);
        check("rerun_writes", wr_cnt - base, 32);
        check("rerun_order_from_0", order_err - oe, 0);

        // start held high: one full run, then a restart only out of DONE.
        do_load();
        base = wr_cnt;
        oe   = order_err;
        run(0, 1, edges);
        check("hold_done_edge", edges, 320);
        check("hold_single_run", wr_cnt - base, 32);
        @(posedge clk);
        #1;
        check("hold_restart_busy", busy, 1);
        check("hold_restart_done", done, 0);
        start = 1'b0;
        wait_done(0, edges);
        check("hold_second_edge", edges, 320);
        check("hold_total_writes", wr_cnt - base, 64);
        check("hold_order", order_err - oe, 0);

        // MSG_LEN = 256 instance on identity S with zero ciphertext.
        for (int x = 0; x < 256; x++) begin
            ms[x] = 8'(x);
            me[x] = 8'h00;
        end
        model_prga(256);
        do_load();
        base = wr_cnt2;
        run(1, 0, edges);
        check("len256_done_edge", edges, 2560);
        check("len256_writes", wr_cnt2 - base, 256);
        check("len256_last_k", last_addr2, 8'd255);
        check("len256_order", order_err2, 0);
        for (int x = 0; x < 256; x++) check($sformatf("len256_d%0d", x), d_mem2[x], md[x]);
        check("len256_key_fail", key_fail2, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
- Parametrised RC4 PRGA decrypt engine, successor to the fixed 32-byte decrypt loop of the key-search datapath.
- Runs after the S-array init and key-schedule blocks have filled the shared 256x8 S memory.
- Generates the keystream, XORs it with the encrypted-message ROM and writes plaintext to the decrypted-message RAM.
- Adds configurable message length, a start/busy/done handshake, asynchronous reset, and optional early abort on non-text output.

Parameters:
- MSG_LEN, 32: number of message bytes to decrypt; legal range 2..256.
- K_W, $clog2(MSG_LEN): width of message address/index k (derived; must not be overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE or DONE.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  high while in DONE; held until the next accepted start.
- key_fail  out  1  abort flag (optional feature); otherwise constant 0.
- s_addr  out  8  S memory address.
- s_wdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- s_rdata  in  8  S memory read data; synchronous, 1-cycle latency.
- e_addr  out  K_W  encrypted ROM address (= k).
- e_rdata  in  8  encrypted ROM data; 1-cycle latency.
- d_addr  out  K_W  decrypted RAM address (= k).
- d_wdata  out  8  decrypted RAM write data.
- d_wren  out  1  decrypted RAM write enable.

Behaviour:
- Moore FSM. All enables, addresses and mux selects decode from state only. Internal registers: i, j, si, sj, f, e (8 bit each); k (K_W bit).
- Reset: state=IDLE; i, j, si, sj, f, e, k = 0. busy, done, key_fail, s_wren and d_wren = 0. Address outputs = 0.
- Reset mid-operation: the operation is abandoned. No write enable may be high after reset asserts. Memory contents are left as they stand.
- IDLE or DONE with start=1: clear i, j and k; clear done and key_fail; go to INC_I. In DONE with start=0: stay in DONE.
- Per-byte sequence, 10 cycles:
  - INC_I: i <= i+1.
  - RD_SI: s_addr = i.
  - CALC_J: si <= s_rdata; j <= j + s_rdata.
  - RD_SJ: s_addr = j.
  - LD_SJ: sj <= s_rdata.
  - WR_I: s_addr = i, s_wdata = sj, s_wren = 1.
  - WR_J: s_addr = j, s_wdata = si, s_wren = 1.
  - RD_F: s_addr = si+sj, e_addr = k.
  - LD_F: f <= s_rdata; e <= e_rdata.
  - WR_D: d_addr = k, d_wdata = f^e, d_wren = 1. If k == MSG_LEN-1, go to DONE. Otherwise k <= k+1 and go to INC_I.
- Arithmetic: all 8-bit sums wrap mod 256, including i, j and si+sj. k never wraps; MSG_LEN terminates the loop.
- When i == j, WR_I and WR_J both write the same location. The final value equals the original value, so no special case is needed.
- Latency: the start-sampling edge is edge 0. DONE is entered at edge 10*MSG_LEN (320 for the default).
- Exactly MSG_LEN d_wren pulses per run, with k ascending 0..MSG_LEN-1.
- start while busy is ignored. A new start while in DONE reruns on the current S contents; the upstream sequencer must reinitialise S first.

Optional Feature:
- Macro: PLAINTEXT_CHECK_EN.
- Defined: in WR_D, the byte f^e is checked against lowercase 'a'..'z' (0x61..0x7A) or space (0x20).
  - An out-of-range byte is still written.
  - The FSM then goes to DONE with key_fail=1, regardless of k.
  - key_fail holds until the next accepted start or reset.
  - The run is therefore shorter than 10*MSG_LEN cycles.
- Undefined: key_fail is tied to 0 and all MSG_LEN bytes are always processed.

Test Plan:
- Identity S (S[x]=x), e=0x00 for all bytes, start pulse → d[0]=0x02 and d[1]=0x05; S[2]=0x03 and S[3]=0x02 after the second byte; done at edge 320.
- Same run, scoreboard against a software RC4 model with S from key 0x000249 after KSA → all 32 plaintext bytes and the final S array match.
- reset_n low during WR_D of byte 5 → s_wren=d_wren=0 immediately; busy=done=0; next start reruns from k=0.
- start held high through the whole run → single run, no restart mid-run; a second run starts only from DONE.
- MSG_LEN=256 build → k reaches 255 with no wrap; done at edge 2560; exactly 256 d_wren pulses.
- PLAINTEXT_CHECK_EN, identity S, e[0]=0x63 → d[0]=0x61 passes; e[1]=0x00 → d[1]=0x05 fails; key_fail=1 and done=1 at edge 20; no write to d[2].
